// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared constants, state encoding and sizing helper for the double-dabble converter
package bin_to_bcd_seq_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADD3_VAL = 4'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// add3_digit: combinational double-dabble correction, adds 3 to a BCD digit of 5 or more
module add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = d >= ADD3_THRESH ? d + ADD3_VAL : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative binary-to-BCD converter, one bit per clock, valid/ready on both sides
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = DIGIT_W * DIGITS;
  localparam longint unsigned MAXV = (64'd1 << BIN_W) - 64'd1;
  if (pow10(DIGITS) <= MAXV) begin : g_size_chk
    $fatal(1, "bin_to_bcd_seq: DIGITS too small for BIN_W");
  end
  state_t state, state_n;
  logic [BIN_W-1:0] binreg;
  logic [SW-1:0] scratch, adj;
  logic [CW-1:0] cnt;
  logic [SW+BIN_W-1:0] sh;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    add3_digit u_add3 (.d(scratch[DIGIT_W*i +: DIGIT_W]), .q(adj[DIGIT_W*i +: DIGIT_W]));
  end
  assign sh = {adj, binreg} << 1;
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) :
              state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      binreg <= '0;
      scratch <= '0;
      cnt <= '0;
      bcd <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        binreg <= bin;
        scratch <= '0;
        cnt <= CW'(BIN_W);
      end else if (state == SHIFT) begin
        scratch <= sh[SW+BIN_W-1:BIN_W];
        binreg <= sh[BIN_W-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) bcd <= sh[SW+BIN_W-1:BIN_W];
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and sweep checks of the sequential binary-to-BCD converter
module tb_bin_to_bcd_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [7:0] bin = '0;
  logic [11:0] bcd;
  int checks = 0, failures = 0;
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic run(input logic [7:0] b, output int lat);
    int w = 0;
    while (!in_ready && w < 30) begin @(posedge clk); #1; w++; end
    in_valid = 1; bin = b;
    @(posedge clk); #1;
    in_valid = 0; bin = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_zero;
    int lat;
    run(8'd0, lat);
    checks++; if (lat != 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL zero_bcd got=%h exp=000", bcd); end
  endtask
  task automatic test_max;
    int lat;
    logic [11:0] xs3;
    run(8'd255, lat);
    checks++; if (lat != 8) begin failures++; $display("FAIL max_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h255) begin failures++; $display("FAIL max_bcd got=%h exp=255", bcd); end
    xs3 = {bcd[11:8] + 4'd3, bcd[7:4] + 4'd3, bcd[3:0] + 4'd3};
    checks++; if (xs3 !== 12'h588) begin failures++; $display("FAIL max_xs3 got=%h exp=588", xs3); end
  endtask
  task automatic test_back_to_back;
    int lat;
    out_ready = 1;
    run(8'd99, lat);
    checks++; if (bcd !== 12'h099) begin failures++; $display("FAIL b2b_first got=%h exp=099", bcd); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_done got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_handoff got=%b%b exp=10", in_ready, out_valid); end
    run(8'd128, lat);
    checks++; if (lat != 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h128) begin failures++; $display("FAIL b2b_second got=%h exp=128", bcd); end
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure;
    int lat;
    out_ready = 0;
    run(8'd170, lat);
    checks++; if (bcd !== 12'h170) begin failures++; $display("FAIL bp_bcd got=%h exp=170", bcd); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || bcd !== 12'h170) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/170", i, out_valid, bcd); end
    end
    out_ready = 1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
    checks++; if (bcd !== 12'h170) begin failures++; $display("FAIL bp_keep_bcd got=%h exp=170", bcd); end
  endtask
  task automatic test_reset_mid;
    int lat;
    in_valid = 1; bin = 8'd200;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || bcd !== 12'h000) begin failures++; $display("FAIL midrst got=%b%b/%h exp=00/000", out_valid, in_ready, bcd); end
    @(posedge clk); #1;
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b%b exp=10", in_ready, out_valid); end
    in_valid = 1; bin = 8'd37;
    @(posedge clk); #1;
    in_valid = 0; bin = 8'd5;
    lat = 1;
    @(posedge clk); #1;
    in_valid = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    in_valid = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h037) begin failures++; $display("FAIL ignore_bcd got=%h exp=037", bcd); end
    @(posedge clk); #1;
  endtask
  task automatic test_sweep;
    int lat;
    for (int v = 0; v < 256; v++) begin
      run(8'(v), lat);
      checks++; if (lat != 8) begin failures++; $display("FAIL sweep_latency v=%0d got=%0d exp=8", v, lat); end
      checks++; if (bcd !== ref_bcd(v)) begin failures++; $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); end
      checks++; if (bcd[11:8] > 9 || bcd[7:4] > 9 || bcd[3:0] > 9) begin failures++; $display("FAIL sweep_digit v=%0d got=%h exp=digits<=9", v, bcd); end
    end
  endtask
  initial begin
    test_reset;
    test_zero;
    test_max;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
